// File: rtl/cla_pipe_adder.sv
// WIDTH-bit add/subtract pipelined as one 4-bit carry-lookahead group per stage.
// Valid/ready flow control; a full output that is not taken freezes the whole pipe.
module cla_pipe_adder #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);
   localparam int NGRP = WIDTH / 4;
   localparam int LAT  = NGRP;

   // Four-bit lookahead group: returns {carry_out, sum[3:0]}.
   function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                       input logic c);
      logic [3:0] g;
      logic [3:0] p;
      logic [4:0] cv;
      g     = x & y;
      p     = x ^ y;
      cv[0] = c;
      cv[1] = g[0] | (p[0] & c);
      cv[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
      cv[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
      cv[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
            | (p[3] & p[2] & p[1] & p[0] & c);
      return {cv[4], p ^ cv[3:0]};
   endfunction

   // r_as[k]: finished sum groups shifted in from the top, remaining A groups
   // right-justified below them. After the last stage it holds the full sum.
   logic [WIDTH-1:0] r_as [LAT];
   logic [WIDTH-1:0] r_b  [LAT];
   logic [LAT-1:0]   r_vld;
   logic [LAT-1:0]   r_cy;
   logic             r_ovf;
   logic             r_zero;

   logic [WIDTH-1:0] w_src_as [LAT];
   logic [WIDTH-1:0] w_src_b  [LAT];
   logic [WIDTH-1:0] w_nxt_as [LAT];
   logic [4:0]       w_res    [LAT];
   logic [LAT-1:0]   w_src_v;
   logic [LAT-1:0]   w_src_c;
   logic [WIDTH-1:0] w_bx;
   logic             w_c0;
   logic             w_stall;

   assign w_bx     = sub ? ~b : b;
   assign w_c0     = cin ^ sub;
   assign w_stall  = r_vld[LAT-1] & ~out_ready;
   assign in_ready = ~w_stall;

   for (genvar k = 0; k < LAT; k++) begin : g_stg
      if (k == 0) begin : g_head
         assign w_src_as[k] = a;
         assign w_src_b[k]  = w_bx;
         assign w_src_c[k]  = w_c0;
         assign w_src_v[k]  = in_valid & ~w_stall;
      end else begin : g_body
         assign w_src_as[k] = r_as[k-1];
         assign w_src_b[k]  = r_b[k-1];
         assign w_src_c[k]  = r_cy[k-1];
         assign w_src_v[k]  = r_vld[k-1];
      end
      assign w_res[k]    = cla4(w_src_as[k][3:0], w_src_b[k][3:0], w_src_c[k]);
      assign w_nxt_as[k] = (w_src_as[k] >> 4) | (WIDTH'(w_res[k][3:0]) << (WIDTH - 4));
   end

   // Data registers load only with a valid slot, so outputs keep the last
   // result (never X) while invalid slots pass through.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld  <= '0;
         r_cy   <= '0;
         r_ovf  <= 1'b0;
         r_zero <= 1'b0;
         for (int k = 0; k < LAT; k++) begin
            r_as[k] <= '0;
            r_b[k]  <= '0;
         end
      end else if (!w_stall) begin
         r_vld <= w_src_v;
         for (int k = 0; k < LAT; k++) begin
            if (w_src_v[k]) begin
               r_as[k] <= w_nxt_as[k];
               r_b[k]  <= w_src_b[k] >> 4;
               r_cy[k] <= w_res[k][4];
            end
         end
         if (w_src_v[LAT-1]) begin
            r_ovf  <= (w_src_as[LAT-1][3] == w_src_b[LAT-1][3]) &&
                      (w_res[LAT-1][3] != w_src_as[LAT-1][3]);
            r_zero <= (w_nxt_as[LAT-1] == '0);
         end
      end
   end

   assign out_valid = r_vld[LAT-1];
   assign sum       = r_as[LAT-1];
   assign cout      = r_cy[LAT-1];
   assign ovf       = r_ovf;
   assign zero      = r_zero;
endmodule
